// File: rtl/equation_round_sequencer.sv
// Game-level scheduler for the equation units.
// Runs NUM_ROUNDS timed rounds, handing a start level to one unit per round
// (round-robin), counting down a per-round timer, collecting the verdict and
// aborting the active unit when its time runs out.
module equation_round_sequencer #(
  parameter int unsigned NUM_EQ     = 3,
  parameter int unsigned NUM_ROUNDS = 5,
  parameter int unsigned ROUND_TIME = 60,
  parameter int unsigned TICK_DIV   = 50_000_000
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              start_game,
  input  logic              eq_done,
  input  logic              eq_correct,
  output logic [NUM_EQ-1:0] start_eq,
  output logic              eq_abort,
  output logic [6:0]        ongoing_timer,
  output logic [3:0]        round_num,
  output logic [3:0]        score,
  output logic              busy,
  output logic              game_over
);

  localparam int unsigned SelW = (NUM_EQ > 1) ? $clog2(NUM_EQ) : 1;
  localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StRun,
    StTimeout,
    StResult,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [SelW-1:0] sel_q, sel_d;
  logic [PreW-1:0] pre_q, pre_d;
  logic [6:0]      timer_q, timer_d;
  logic [3:0]      round_q, round_d;
  logic [3:0]      score_q, score_d;

  // State and datapath registers; synchronous reset wins in every state.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= StIdle;
      sel_q   <= '0;
      pre_q   <= '0;
      timer_q <= '0;
      round_q <= '0;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      pre_q   <= pre_d;
      timer_q <= timer_d;
      round_q <= round_d;
      score_q <= score_d;
    end
  end

  // Next-state and datapath updates for the round sequence.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    pre_d   = pre_q;
    timer_d = timer_q;
    round_d = round_q;
    score_d = score_q;
    unique case (state_q)
      StIdle: begin
        if (start_game) begin
          state_d = StLaunch;
          score_d = '0;
          round_d = '0;
          sel_d   = '0;
        end
      end
      StLaunch: begin
        timer_d = 7'(ROUND_TIME);
        pre_d   = '0;
        state_d = StRun;
      end
      StRun: begin
        // A verdict beats a timeout arriving on the same cycle.
        if (eq_done) begin
          state_d = StResult;
          if (eq_correct && (score_q != 4'd15)) begin
            score_d = score_q + 4'd1;
          end
        end else if (timer_q == 7'd0) begin
          state_d = StTimeout;
        end else if (pre_q == PreW'(TICK_DIV - 1)) begin
          pre_d   = '0;
          timer_d = timer_q - 7'd1;
        end else begin
          pre_d = pre_q + PreW'(1);
        end
      end
      StTimeout: begin
        state_d = StResult;
      end
      StResult: begin
        round_d = round_q + 4'd1;
        sel_d   = (sel_q == SelW'(NUM_EQ - 1)) ? '0 : sel_q + SelW'(1);
        state_d = (round_q == 4'(NUM_ROUNDS - 1)) ? StDone : StLaunch;
      end
      StDone: begin
        if (!start_game) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from the registered state; eq_abort is a clean one-cycle pulse.
  always_comb begin
    start_eq = '0;
    for (int i = 0; i < NUM_EQ; i++) begin
      start_eq[i] = ((state_q == StLaunch) || (state_q == StRun)) && (sel_q == SelW'(i));
    end
    eq_abort      = (state_q == StTimeout);
    busy          = (state_q != StIdle) && (state_q != StDone);
    game_over     = (state_q == StDone);
    ongoing_timer = timer_q;
    round_num     = round_q;
    score         = score_q;
  end

endmodule

// File: tb/tb_equation_round_sequencer.sv
// Directed bench for equation_round_sequencer with short ticks and rounds.
module tb_equation_round_sequencer;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       start_game = 1'b0;
  logic       eq_done = 1'b0;
  logic       eq_correct = 1'b0;
  logic [2:0] start_eq;
  logic       eq_abort;
  logic [6:0] ongoing_timer;
  logic [3:0] round_num;
  logic [3:0] score;
  logic       busy;
  logic       game_over;

  int total = 0;
  int bad = 0;

  equation_round_sequencer #(
    .NUM_EQ    (3),
    .NUM_ROUNDS(5),
    .ROUND_TIME(3),
    .TICK_DIV  (4)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .start_game   (start_game),
    .eq_done      (eq_done),
    .eq_correct   (eq_correct),
    .start_eq     (start_eq),
    .eq_abort     (eq_abort),
    .ongoing_timer(ongoing_timer),
    .round_num    (round_num),
    .score        (score),
    .busy         (busy),
    .game_over    (game_over)
  );

  always #5 Clock = ~Clock;

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // From LAUNCH: enter RUN, answer at once, land on LAUNCH or DONE.
  task automatic answer_round(input logic correct);
    step();
    eq_done = 1'b1;
    eq_correct = correct;
    step();
    eq_done = 1'b0;
    eq_correct = 1'b0;
    step();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
    total++; if (start_eq !== 3'b000) begin bad++; $display("FAIL reset_start_eq got %b want 000", start_eq); end
    total++; if (eq_abort !== 1'b0) begin bad++; $display("FAIL reset_abort got %b want 0", eq_abort); end
    total++; if (ongoing_timer !== 7'd0) begin bad++; $display("FAIL reset_timer got %0d want 0", ongoing_timer); end
    total++; if (round_num !== 4'd0) begin bad++; $display("FAIL reset_round got %0d want 0", round_num); end
    total++; if (score !== 4'd0) begin bad++; $display("FAIL reset_score got %0d want 0", score); end
    total++; if (busy !== 1'b0 || game_over !== 1'b0) begin bad++; $display("FAIL reset_flags got busy=%b go=%b want 0 0", busy, game_over); end
    start_game = 1'b1;
    step();
    start_game = 1'b0;
    step();
    total++; if (start_eq !== 3'b001) begin bad++; $display("FAIL launch_start_eq got %b want 001", start_eq); end
    total++; if (ongoing_timer !== 7'd3) begin bad++; $display("FAIL launch_timer got %0d want 3", ongoing_timer); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL launch_busy got %b want 1", busy); end
  endtask

  task automatic test_timeout();
    // In RUN with timer=3 and prescaler=0; one tick every 4 RUN cycles.
    for (int k = 2; k >= 0; k--) begin
      repeat (3) step();
      total++; if (ongoing_timer !== 7'(k + 1)) begin bad++; $display("FAIL tick_hold got %0d want %0d", ongoing_timer, k + 1); end
      step();
      total++; if (ongoing_timer !== 7'(k)) begin bad++; $display("FAIL tick_dec got %0d want %0d", ongoing_timer, k); end
    end
    total++; if (eq_abort !== 1'b0) begin bad++; $display("FAIL abort_early got %b want 0", eq_abort); end
    step();
    total++; if (eq_abort !== 1'b1) begin bad++; $display("FAIL abort_pulse got %b want 1", eq_abort); end
    total++; if (ongoing_timer !== 7'd0) begin bad++; $display("FAIL timer_hold0 got %0d want 0", ongoing_timer); end
    step();
    total++; if (eq_abort !== 1'b0) begin bad++; $display("FAIL abort_len got %b want 0", eq_abort); end
    total++; if (start_eq !== 3'b000) begin bad++; $display("FAIL result_gap got %b want 000", start_eq); end
    step();
    total++; if (score !== 4'd0) begin bad++; $display("FAIL timeout_score got %0d want 0", score); end
    total++; if (round_num !== 4'd1) begin bad++; $display("FAIL timeout_round got %0d want 1", round_num); end
    total++; if (start_eq !== 3'b010) begin bad++; $display("FAIL rr_sel1 got %b want 010", start_eq); end
  endtask

  task automatic test_verdicts();
    answer_round(1'b1);
    total++; if (score !== 4'd1) begin bad++; $display("FAIL correct_score got %0d want 1", score); end
    total++; if (start_eq !== 3'b100) begin bad++; $display("FAIL rr_sel2 got %b want 100", start_eq); end
    answer_round(1'b0);
    total++; if (score !== 4'd1) begin bad++; $display("FAIL wrong_score got %0d want 1", score); end
    total++; if (start_eq !== 3'b001) begin bad++; $display("FAIL rr_wrap got %b want 001", start_eq); end
    total++; if (round_num !== 4'd3) begin bad++; $display("FAIL round3 got %0d want 3", round_num); end
    answer_round(1'b1);
    answer_round(1'b1);
    total++; if (game_over !== 1'b1 || round_num !== 4'd5 || score !== 4'd3) begin
      bad++; $display("FAIL game1_end got go=%b round=%0d score=%0d want 1 5 3", game_over, round_num, score);
    end
    // A stray done pulse in DONE must not score.
    eq_done = 1'b1;
    eq_correct = 1'b1;
    step();
    eq_done = 1'b0;
    eq_correct = 1'b0;
    total++; if (score !== 4'd3 || game_over !== 1'b0) begin
      bad++; $display("FAIL stray_done got score=%0d go=%b want 3 0", score, game_over);
    end
  endtask

  task automatic test_full_game();
    start_game = 1'b1;
    step();
    total++; if (score !== 4'd0 || round_num !== 4'd0) begin
      bad++; $display("FAIL restart_clear got score=%0d round=%0d want 0 0", score, round_num);
    end
    for (int r = 0; r < 5; r++) answer_round(1'b1);
    total++; if (game_over !== 1'b1) begin bad++; $display("FAIL done_go got %b want 1", game_over); end
    total++; if (score !== 4'd5 || round_num !== 4'd5) begin
      bad++; $display("FAIL done_counts got score=%0d round=%0d want 5 5", score, round_num);
    end
    total++; if (start_eq !== 3'b000 || busy !== 1'b0) begin
      bad++; $display("FAIL done_idle got start_eq=%b busy=%b want 000 0", start_eq, busy);
    end
    step();
    total++; if (game_over !== 1'b1) begin bad++; $display("FAIL done_hold got %b want 1", game_over); end
    start_game = 1'b0;
    step();
    total++; if (game_over !== 1'b0 || busy !== 1'b0 || score !== 4'd5) begin
      bad++; $display("FAIL idle_after got go=%b busy=%b score=%0d want 0 0 5", game_over, busy, score);
    end
    start_game = 1'b1;
    step();
    start_game = 1'b0;
    total++; if (score !== 4'd0 || round_num !== 4'd0 || busy !== 1'b1) begin
      bad++; $display("FAIL new_game got score=%0d round=%0d busy=%b want 0 0 1", score, round_num, busy);
    end
  endtask

  task automatic test_done_at_zero();
    step();
    repeat (12) step();
    total++; if (ongoing_timer !== 7'd0) begin bad++; $display("FAIL zero_reached got %0d want 0", ongoing_timer); end
    eq_done = 1'b1;
    eq_correct = 1'b1;
    step();
    eq_done = 1'b0;
    eq_correct = 1'b0;
    total++; if (score !== 4'd1 || eq_abort !== 1'b0) begin
      bad++; $display("FAIL zero_done got score=%0d abort=%b want 1 0", score, eq_abort);
    end
    step();
    total++; if (eq_abort !== 1'b0 || round_num !== 4'd1 || start_eq !== 3'b010) begin
      bad++; $display("FAIL zero_next got abort=%b round=%0d start_eq=%b want 0 1 010", eq_abort, round_num, start_eq);
    end
  endtask

  task automatic test_reset_mid_run();
    step();
    repeat (4) step();
    total++; if (ongoing_timer !== 7'd2) begin bad++; $display("FAIL mid_timer got %0d want 2", ongoing_timer); end
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    total++; if (start_eq !== 3'b000 || eq_abort !== 1'b0 || ongoing_timer !== 7'd0 || round_num !== 4'd0
                 || score !== 4'd0 || busy !== 1'b0 || game_over !== 1'b0) begin
      bad++; $display("FAIL mid_reset got start_eq=%b abort=%b timer=%0d round=%0d score=%0d busy=%b go=%b want all 0",
                      start_eq, eq_abort, ongoing_timer, round_num, score, busy, game_over);
    end
    step();
    total++; if (eq_abort !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL post_reset got abort=%b busy=%b want 0 0", eq_abort, busy);
    end
    start_game = 1'b1;
    step();
    start_game = 1'b0;
    step();
    total++; if (start_eq !== 3'b001 || ongoing_timer !== 7'd3) begin
      bad++; $display("FAIL restart got start_eq=%b timer=%0d want 001 3", start_eq, ongoing_timer);
    end
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_verdicts();
    test_full_game();
    test_done_at_zero();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
